// File: rtl/quantize_stream.sv
`timescale 1ns/1ps
// Streaming JPEG quantizer: divides Q16.16 DCT coefficients by Annex K luma/chroma
// table entries via reciprocal multiply, rounds half away from zero and saturates.
module quantize_stream #(
  parameter int DATA_WIDTH  = 32,
  parameter int FRAC_BITS   = 16,
  parameter int OUT_WIDTH   = 12,
  parameter int LANES       = 1,
  parameter int PIXEL_COUNT = 64
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [LANES*DATA_WIDTH-1:0]  in_data,
  input  logic                         in_chroma,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [LANES*OUT_WIDTH-1:0]   out_data,
  output logic [5:0]                   out_idx,
  output logic                         out_last,
  output logic                         out_chroma
);

  localparam int PW = DATA_WIDTH + 18;
  localparam int RW = 17;
  localparam logic [5:0] LAST_IDX = 6'(PIXEL_COUNT - LANES);
  localparam logic [PW-1:0] HALF = PW'(1) << (FRAC_BITS + 15);
  localparam logic [PW-1:0] LIM = PW'(2 ** (OUT_WIDTH - 1));
  localparam logic [OUT_WIDTH-1:0] OUT_MAX = {1'b0, {(OUT_WIDTH-1){1'b1}}};
  localparam logic [OUT_WIDTH-1:0] OUT_MIN = {1'b1, {(OUT_WIDTH-1){1'b0}}};

  localparam int unsigned Q_LUMA [64] = '{
    16, 11, 10, 16, 24, 40, 51, 61,
    12, 12, 14, 19, 26, 58, 60, 55,
    14, 13, 16, 24, 40, 57, 69, 56,
    14, 17, 22, 29, 51, 87, 80, 62,
    18, 22, 37, 56, 68, 109, 103, 77,
    24, 35, 55, 64, 81, 104, 113, 92,
    49, 64, 78, 87, 103, 121, 120, 101,
    72, 92, 95, 98, 112, 100, 103, 99};

  localparam int unsigned Q_CHROMA [64] = '{
    17, 18, 24, 47, 99, 99, 99, 99,
    18, 21, 26, 66, 99, 99, 99, 99,
    24, 26, 56, 99, 99, 99, 99, 99,
    47, 66, 99, 99, 99, 99, 99, 99,
    99, 99, 99, 99, 99, 99, 99, 99,
    99, 99, 99, 99, 99, 99, 99, 99,
    99, 99, 99, 99, 99, 99, 99, 99,
    99, 99, 99, 99, 99, 99, 99, 99};

  function automatic logic [RW-1:0] recip_of(input int unsigned q);
    return RW'((32'd131072 + q) / (32'd2 * q));
  endfunction

  // Sign-magnitude rounding keeps the half-away-from-zero rule symmetric.
  function automatic logic [OUT_WIDTH-1:0] round_sat(input logic [PW-1:0] p);
    logic [PW-1:0] mag;
    logic [PW-1:0] rnd;
    mag = p[PW-1] ? (~p + PW'(1)) : p;
    rnd = (mag + HALF) >> (FRAC_BITS + 16);
    if (p[PW-1]) return (rnd >= LIM) ? OUT_MIN : OUT_WIDTH'(PW'(0) - rnd);
    return (rnd >= LIM) ? OUT_MAX : OUT_WIDTH'(rnd);
  endfunction

  logic [RW-1:0] recip_l [64];
  logic [RW-1:0] recip_c [64];

  for (genvar g = 0; g < 64; g++) begin : g_recip
    assign recip_l[g] = recip_of(Q_LUMA[g]);
    assign recip_c[g] = recip_of(Q_CHROMA[g]);
  end

  logic en, accept, beat_chroma;
  logic [5:0] idx_q, idx_d;
  logic chroma_sel_q, chroma_sel_d;

  logic v1_q, v1_d, ch1_q, ch1_d;
  logic [5:0] idx1_q, idx1_d;
  logic [LANES*DATA_WIDTH-1:0] x1_q, x1_d;
  logic [LANES*RW-1:0] r1_q, r1_d;

  logic v2_q, v2_d, ch2_q, ch2_d;
  logic [5:0] idx2_q, idx2_d;
  logic [LANES*PW-1:0] p2_q, p2_d;

  logic out_valid_q, out_valid_d, out_last_q, out_last_d, out_chroma_q, out_chroma_d;
  logic [5:0] out_idx_q, out_idx_d;
  logic [LANES*OUT_WIDTH-1:0] out_data_q, out_data_d;

  always_comb begin
    en = !out_valid_q || out_ready;
    accept = in_valid && en;
    beat_chroma = (idx_q == 6'd0) ? in_chroma : chroma_sel_q;
    idx_d = idx_q;
    chroma_sel_d = chroma_sel_q;
    v1_d = v1_q; ch1_d = ch1_q; idx1_d = idx1_q; x1_d = x1_q; r1_d = r1_q;
    v2_d = v2_q; ch2_d = ch2_q; idx2_d = idx2_q; p2_d = p2_q;
    out_valid_d = out_valid_q; out_last_d = out_last_q; out_chroma_d = out_chroma_q;
    out_idx_d = out_idx_q; out_data_d = out_data_q;

    if (accept) begin
      idx_d = (idx_q == LAST_IDX) ? 6'd0 : idx_q + 6'(LANES);
      chroma_sel_d = beat_chroma;
    end

    if (en) begin
      v1_d = accept;
      v2_d = v1_q;
      out_valid_d = v2_q;
      if (accept) begin
        x1_d = in_data;
        idx1_d = idx_q;
        ch1_d = beat_chroma;
        for (int j = 0; j < LANES; j++)
          r1_d[j*RW +: RW] = beat_chroma ? recip_c[idx_q + 6'(j)] : recip_l[idx_q + 6'(j)];
      end
      if (v1_q) begin
        idx2_d = idx1_q;
        ch2_d = ch1_q;
        for (int j = 0; j < LANES; j++)
          p2_d[j*PW +: PW] = PW'($signed(x1_q[j*DATA_WIDTH +: DATA_WIDTH]))
                           * PW'($signed({1'b0, r1_q[j*RW +: RW]}));
      end
      if (v2_q) begin
        out_idx_d = idx2_q;
        out_last_d = (idx2_q == LAST_IDX);
        out_chroma_d = ch2_q;
        for (int j = 0; j < LANES; j++)
          out_data_d[j*OUT_WIDTH +: OUT_WIDTH] = round_sat(p2_q[j*PW +: PW]);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q <= '0; chroma_sel_q <= 1'b0;
      v1_q <= 1'b0; ch1_q <= 1'b0; idx1_q <= '0; x1_q <= '0; r1_q <= '0;
      v2_q <= 1'b0; ch2_q <= 1'b0; idx2_q <= '0; p2_q <= '0;
      out_valid_q <= 1'b0; out_last_q <= 1'b0; out_chroma_q <= 1'b0;
      out_idx_q <= '0; out_data_q <= '0;
    end else begin
      idx_q <= idx_d; chroma_sel_q <= chroma_sel_d;
      v1_q <= v1_d; ch1_q <= ch1_d; idx1_q <= idx1_d; x1_q <= x1_d; r1_q <= r1_d;
      v2_q <= v2_d; ch2_q <= ch2_d; idx2_q <= idx2_d; p2_q <= p2_d;
      out_valid_q <= out_valid_d; out_last_q <= out_last_d; out_chroma_q <= out_chroma_d;
      out_idx_q <= out_idx_d; out_data_q <= out_data_d;
    end
  end

  assign in_ready = en;
  assign out_valid = out_valid_q;
  assign out_data = out_data_q;
  assign out_idx = out_idx_q;
  assign out_last = out_last_q;
  assign out_chroma = out_chroma_q;

endmodule

// File: tb/tb_quantize_stream.sv
`timescale 1ns/1ps
// Bench for quantize_stream: one LANES=1 and one LANES=4 instance, each checked
// beat-by-beat against an arithmetic model of the quantizer.
module tb_quantize_stream;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  logic in_valid1, in_ready1, in_chroma1, out_valid1, out_ready1, out_last1, out_chroma1;
  logic [31:0] in_data1;
  logic [11:0] out_data1;
  logic [5:0] out_idx1;

  logic in_valid4, in_ready4, in_chroma4, out_valid4, out_ready4, out_last4, out_chroma4;
  logic [127:0] in_data4;
  logic [47:0] out_data4;
  logic [5:0] out_idx4;

  quantize_stream #(.LANES(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid1), .in_ready(in_ready1),
    .in_data(in_data1), .in_chroma(in_chroma1), .out_valid(out_valid1),
    .out_ready(out_ready1), .out_data(out_data1), .out_idx(out_idx1),
    .out_last(out_last1), .out_chroma(out_chroma1));

  quantize_stream #(.LANES(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid4), .in_ready(in_ready4),
    .in_data(in_data4), .in_chroma(in_chroma4), .out_valid(out_valid4),
    .out_ready(out_ready4), .out_data(out_data4), .out_idx(out_idx4),
    .out_last(out_last4), .out_chroma(out_chroma4));

  localparam int QL [64] = '{
    16, 11, 10, 16, 24, 40, 51, 61,   12, 12, 14, 19, 26, 58, 60, 55,
    14, 13, 16, 24, 40, 57, 69, 56,   14, 17, 22, 29, 51, 87, 80, 62,
    18, 22, 37, 56, 68, 109, 103, 77, 24, 35, 55, 64, 81, 104, 113, 92,
    49, 64, 78, 87, 103, 121, 120, 101, 72, 92, 95, 98, 112, 100, 103, 99};
  localparam int QC [64] = '{
    17, 18, 24, 47, 99, 99, 99, 99,   18, 21, 26, 66, 99, 99, 99, 99,
    24, 26, 56, 99, 99, 99, 99, 99,   47, 66, 99, 99, 99, 99, 99, 99,
    99, 99, 99, 99, 99, 99, 99, 99,   99, 99, 99, 99, 99, 99, 99, 99,
    99, 99, 99, 99, 99, 99, 99, 99,   99, 99, 99, 99, 99, 99, 99, 99};

  int n_cmp = 0, n_err = 0, cyc = 0;
  always @(posedge clk) cyc++;

  // Quantized value of one Q16.16 coefficient: x * round(65536/Q) / 2^32, rounded, clamped.
  function automatic int model_q(input logic [31:0] x, input bit chroma, input int k);
    longint q, recip, p, mag, r;
    q = chroma ? QC[k] : QL[k];
    recip = (65536 + q / 2) / q;
    p = longint'($signed(x)) * recip;
    mag = (p < 0) ? -p : p;
    r = (mag + 64'sd2147483648) / 64'sd4294967296;
    if (p < 0) r = -r;
    if (r > 2047) r = 2047;
    if (r < -2048) r = -2048;
    return int'(r);
  endfunction

  typedef struct {
    logic [47:0] data;
    logic [5:0]  idx;
    bit          last;
    bit          ch;
  } beat_t;

  function automatic beat_t model_beat(input logic [127:0] d, input int lanes, input int idx, input bit ch);
    beat_t b;
    b.data = '0;
    for (int j = 0; j < lanes; j++) b.data[j*12 +: 12] = 12'(model_q(d[j*32 +: 32], ch, idx + j));
    b.idx = 6'(idx);
    b.last = (idx == 64 - lanes);
    b.ch = ch;
    return b;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  beat_t q1[$], q4[$];
  int m_idx1 = 0, m_idx4 = 0;
  bit m_ch1 = 0, m_ch4 = 0;
  bit held1 = 0, held4 = 0;
  logic [11:0] hold1_d;
  logic [47:0] hold4_d;
  int first_acc1 = -1, first_out1 = -1;
  int n_out4 = 0, n_last4 = 0;

  // Single compare process: outputs against model queue, stall stability, and model updates on accept.
  always @(negedge clk) begin
    if (!rst_n) begin
      q1.delete(); q4.delete();
      m_idx1 = 0; m_idx4 = 0; m_ch1 = 0; m_ch4 = 0;
      held1 = 0; held4 = 0;
    end else begin
      if (held1) check("stall_hold1", {out_valid1, out_data1}, {1'b1, hold1_d});
      if (out_valid1) begin
        if (first_out1 < 0) first_out1 = cyc;
        if (q1.size() == 0) begin
          n_cmp++; n_err++;
          $display("FAIL extra_beat1: got beat idx %0d expected none", out_idx1);
        end else begin
          check("data1", out_data1, q1[0].data[11:0]);
          check("idx1", out_idx1, q1[0].idx);
          check("last1", out_last1, q1[0].last);
          check("chroma1", out_chroma1, q1[0].ch);
          if (out_ready1) void'(q1.pop_front());
        end
      end
      held1 = out_valid1 && !out_ready1;
      hold1_d = out_data1;
      if (in_valid1 && in_ready1) begin
        if (first_acc1 < 0) first_acc1 = cyc;
        if (m_idx1 == 0) m_ch1 = in_chroma1;
        q1.push_back(model_beat({96'b0, in_data1}, 1, m_idx1, m_ch1));
        m_idx1 = (m_idx1 + 1) % 64;
      end

      if (held4) check("stall_hold4", {out_valid4, out_data4}, {1'b1, hold4_d});
      if (out_valid4) begin
        if (q4.size() == 0) begin
          n_cmp++; n_err++;
          $display("FAIL extra_beat4: got beat idx %0d expected none", out_idx4);
        end else begin
          check("data4", out_data4, q4[0].data);
          check("idx4", out_idx4, q4[0].idx);
          check("last4", out_last4, q4[0].last);
          check("chroma4", out_chroma4, q4[0].ch);
          if (out_ready4) begin
            void'(q4.pop_front());
            n_out4++;
            if (out_last4) n_last4++;
          end
        end
      end
      held4 = out_valid4 && !out_ready4;
      hold4_d = out_data4;
      if (in_valid4 && in_ready4) begin
        if (m_idx4 == 0) m_ch4 = in_chroma4;
        q4.push_back(model_beat(in_data4, 4, m_idx4, m_ch4));
        m_idx4 = (m_idx4 + 4) % 64;
      end
    end
  end

  bit rand_ready = 0;
  initial begin
    out_ready1 = 1'b1;
    out_ready4 = 1'b1;
    forever begin
      @(posedge clk); #2;
      out_ready1 = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      out_ready4 = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  function automatic logic [31:0] rand_coef();
    logic signed [31:0] s;
    s = $urandom;
    return s >>> $urandom_range(0, 24);
  endfunction

  task automatic send1(input logic [31:0] d, input bit ch);
    int t = 0;
    in_valid1 = 1'b1; in_data1 = d; in_chroma1 = ch;
    @(negedge clk);
    while (!in_ready1 && t < 1000) begin t++; @(negedge clk); end
    if (t >= 1000) begin n_cmp++; n_err++; $display("FAIL accept_timeout1: got no in_ready expected accept"); end
    @(posedge clk); #2;
    in_valid1 = 1'b0;
  endtask

  task automatic send4(input logic [127:0] d, input bit ch);
    int t = 0;
    in_valid4 = 1'b1; in_data4 = d; in_chroma4 = ch;
    @(negedge clk);
    while (!in_ready4 && t < 1000) begin t++; @(negedge clk); end
    if (t >= 1000) begin n_cmp++; n_err++; $display("FAIL accept_timeout4: got no in_ready expected accept"); end
    @(posedge clk); #2;
    in_valid4 = 1'b0;
  endtask

  task automatic block1(input logic [31:0] first, input bit ch0, input int toggle_at, input bit rnd);
    for (int i = 0; i < 64; i++)
      send1((i == 0) ? first : (rnd ? rand_coef() : 32'd0),
            (toggle_at >= 0 && i >= toggle_at) ? !ch0 : ch0);
  endtask

  task automatic beats4(input int n, input bit ch);
    for (int i = 0; i < n; i++) send4({rand_coef(), rand_coef(), rand_coef(), rand_coef()}, ch);
  endtask

  task automatic drain();
    int t = 0;
    while ((q1.size() != 0 || q4.size() != 0) && t < 4000) begin @(posedge clk); t++; end
    if (t >= 4000) begin
      n_cmp++; n_err++;
      $display("FAIL drain_timeout: got %0d/%0d pending expected 0", q1.size(), q4.size());
    end
    repeat (4) @(posedge clk);
    #2;
  endtask

  initial begin
    rst_n = 1'b0;
    in_valid1 = 0; in_data1 = '0; in_chroma1 = 0;
    in_valid4 = 0; in_data4 = '0; in_chroma4 = 0;
    repeat (3) @(posedge clk);
    #2;
    check("rst_out_valid1", out_valid1, 0);
    check("rst_out_data1", out_data1, 0);
    check("rst_out_idx1", out_idx1, 0);
    check("rst_out_last1", out_last1, 0);
    check("rst_out_chroma1", out_chroma1, 0);
    check("rst_in_ready1", in_ready1, 1);
    check("rst_out_valid4", out_valid4, 0);
    check("rst_out_data4", out_data4, 0);
    rst_n = 1'b1;
    @(posedge clk); #2;

    check("pin_16p0", 64'(model_q(32'h00100000, 0, 0)), 64'(1));
    check("pin_8p0", 64'(model_q(32'h00080000, 0, 0)), 64'(1));
    check("pin_m8p0", 64'(model_q(32'hFFF80000, 0, 0)), 64'(-1));
    check("pin_below_half", 64'(model_q(32'h0007FFFF, 0, 0)), 64'(0));
    check("pin_17_chroma", 64'(model_q(32'h00110000, 1, 0)), 64'(1));
    check("pin_24_luma", 64'(model_q(32'h00180000, 0, 0)), 64'(2));
    check("pin_24_chroma", 64'(model_q(32'h00180000, 1, 0)), 64'(1));
    check("pin_sat_pos", 64'(model_q(32'h7FFF0000, 0, 0)), 64'(2047));
    check("pin_sat_neg", 64'(model_q(32'h80000000, 0, 0)), 64'(-2048));
    check("pin_luma_k5", 64'(model_q(32'h00280000, 0, 5)), 64'(1));
    check("pin_chroma_k63", 64'(model_q(32'hFFCE0000, 1, 63)), 64'(-1));

    block1(32'h00100000, 0, -1, 0);
    drain();
    check("latency", 64'(first_out1 - first_acc1), 64'(3));

    block1(32'h00080000, 0, -1, 0);
    block1(32'hFFF80000, 0, -1, 0);
    block1(32'h0007FFFF, 0, -1, 0);
    block1(32'h00110000, 1, 10, 1);
    block1(32'h00180000, 0, -1, 1);
    block1(32'h7FFF0000, 0, -1, 0);
    block1(32'h80000000, 0, -1, 0);
    drain();

    rand_ready = 1;
    for (int b = 0; b < 3; b++) block1(rand_coef(), 0, -1, 1);
    drain();
    rand_ready = 0;

    beats4(16, 0);
    beats4(7, 1);
    rst_n = 1'b0;
    #1;
    check("midrst_out_valid4", out_valid4, 0);
    check("midrst_in_ready4", in_ready4, 1);
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b1;
    @(posedge clk); #2;
    n_out4 = 0; n_last4 = 0;
    rand_ready = 1;
    beats4(16, 1);
    beats4(16, 0);
    drain();
    rand_ready = 0;
    check("lanes4_beats", 64'(n_out4), 64'(32));
    check("lanes4_lasts", 64'(n_last4), 64'(2));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
